// File: rtl/seven_segment_scanner.sv
// Purpose : time-multiplexes NUM_DIGITS double-buffered BCD digits onto one num bus with a one-hot digit enable.
// Latency : an accepted load is displayed from the first cycle of the frame after the next frame boundary.
// Backpr. : load_ready drops while the shadow buffer is full and rises the cycle after the frame-end transfer.
// Optional: define SEVEN_SEGMENT_SCANNER_BLANK_EN for leading-zero blanking; by default no slot is ever blanked.
module seven_segment_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic [3:0]              num,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    blank,
   output logic                    frame_tick
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = 4 * NUM_DIGITS;

   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DW-1:0]         disp_q, disp_d;
   logic [DW-1:0]         shad_q, shad_d;
   logic                  sfull_q, sfull_d;

   logic                  tick;
   logic [NUM_DIGITS-1:0] blank_vec;

   // Scan timebase: tick ends a digit slot, frame_tick ends the last slot of a frame
   always_comb begin
      tick       = (pcnt_q == PW'(SCAN_DIV - 1));
      frame_tick = tick && (idx_q == IW'(NUM_DIGITS - 1));
   end

   // Next-state: prescaler, digit index, and shadow/display buffer handoff
   always_comb begin
      pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
      idx_d   = idx_q;
      disp_d  = disp_q;
      shad_d  = shad_q;
      sfull_d = sfull_q;
      if (tick) begin
         idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      // Transfer only at the frame boundary so a frame never mixes old and new digits
      if (frame_tick && sfull_q) begin
         disp_d  = shad_q;
         sfull_d = 1'b0;
      end
      // Accept only into an empty shadow; the two branches are exclusive on sfull_q
      if (load_valid && !sfull_q) begin
         shad_d  = load_data;
         sfull_d = 1'b1;
      end
   end

   // State register with synchronous reset; reset discards both buffers
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q  <= '0;
         idx_q   <= '0;
         disp_q  <= '0;
         shad_q  <= '0;
         sfull_q <= 1'b0;
      end else begin
         pcnt_q  <= pcnt_d;
         idx_q   <= idx_d;
         disp_q  <= disp_d;
         shad_q  <= shad_d;
         sfull_q <= sfull_d;
      end
   end

`ifdef SEVEN_SEGMENT_SCANNER_BLANK_EN
   logic all_zero;

   // Leading-zero mask: slot k blanks when it and every more significant digit are zero; slot 0 never blanks
   always_comb begin
      blank_vec = '0;
      all_zero  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero     = all_zero && (disp_q[4*k +: 4] == 4'd0);
         blank_vec[k] = all_zero;
      end
   end
`else
   // Blanking disabled: every slot is always lit
   always_comb begin
      blank_vec = '0;
   end
`endif

   // Output decode from registers only, so load_data never reaches the display combinationally
   always_comb begin
      num        = '0;
      digit_en   = '0;
      blank      = 1'b0;
      load_ready = !sfull_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            num         = disp_q[4*k +: 4];
            blank       = blank_vec[k];
            digit_en[k] = !blank_vec[k];
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with NUM_DIGITS=4, SCAN_DIV=4.
// Cycle n of a test is the n-th cycle after the reset edge; expectations are keyed by cycle.
module tb_seven_segment_scanner;
   localparam int N  = 4;
   localparam int SD = 4;
`ifdef SEVEN_SEGMENT_SCANNER_BLANK_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [15:0]  load_data = '0;
   logic [3:0]   num;
   logic [3:0]   digit_en;
   logic         blank;
   logic         frame_tick;

   seven_segment_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .num        (num),
      .digit_en   (digit_en),
      .blank      (blank),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int cyc  = 0;
   int base = 0;
   // Free-running edge counter used to key expectations
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string      nm;
      int         at;
      logic [3:0] num;
      logic [3:0] en;
      logic       bl;
      logic       rdy;
      logic       ft;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   function automatic void exp_at(string nm, int n, logic [3:0] e_num, logic [3:0] e_en,
                                  logic e_bl, logic e_rdy, logic e_ft);
      exp_t e;
      e.nm = nm; e.at = base + n; e.num = e_num; e.en = e_en;
      e.bl = e_bl; e.rdy = e_rdy; e.ft = e_ft;
      sb.push_back(e);
   endfunction

   // Enable expected for a slot that is a leading zero (dark only when blanking is built in)
   function automatic logic [3:0] ben(logic [3:0] en);
      return BL ? 4'b0000 : en;
   endfunction

   task automatic go(int n);
      while (cyc < base + n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      base = cyc;
   endtask

   task automatic load(int n, logic [15:0] d);
      go(n);
      load_valid = 1'b1;
      load_data  = d;
      go(n + 1);
      load_valid = 1'b0;
   endtask

   // Monitor: on each falling edge pop every expectation due this cycle and compare
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at < cyc) begin
               errors++;
               $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.nm, e.at, cyc);
            end else if ({num, digit_en, blank, load_ready, frame_tick} !==
                         {e.num, e.en, e.bl, e.rdy, e.ft}) begin
               errors++;
               $display("FAIL %s: got num=%h en=%b blank=%b rdy=%b ft=%b, want num=%h en=%b blank=%b rdy=%b ft=%b",
                        e.nm, num, digit_en, blank, load_ready, frame_tick,
                        e.num, e.en, e.bl, e.rdy, e.ft);
            end
         end
         if (done) begin
            checks++;
            if (sb.size() != 0) begin
               errors++;
               $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   // Stimulus: directed tests, each pushing its hand-computed expectations up front
   initial begin : stim
      // Reset state, scan sequence, and a load at cycle 2
      do_reset();
      exp_at("rst_c0", 0, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c2",  2, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c3",  3, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b0);
      exp_at("t1_c4",  4, 4'h0, 4'b0010, 1'b0, 1'b0, 1'b0);
      exp_at("t1_c8",  8, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b0);
      exp_at("t1_c12", 12, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b0);
      exp_at("t1_c14", 14, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b0);
      exp_at("t1_c15", 15, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b1);
      exp_at("t1_c16", 16, 4'h4, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c19", 19, 4'h4, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c20", 20, 4'h3, 4'b0010, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c24", 24, 4'h2, 4'b0100, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c28", 28, 4'h1, 4'b1000, 1'b0, 1'b1, 1'b0);
      exp_at("t1_c31", 31, 4'h1, 4'b1000, 1'b0, 1'b1, 1'b1);
      exp_at("t1_c32", 32, 4'h4, 4'b0001, 1'b0, 1'b1, 1'b0);
      load(2, 16'h1234);
      go(33);

      // Backpressure: 5678 held valid from cycle 3, accepted at cycle 16
      do_reset();
      exp_at("t2_c3",  3, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b0);
      exp_at("t2_c15", 15, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b1);
      exp_at("t2_c16", 16, 4'h4, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t2_c17", 17, 4'h4, 4'b0001, 1'b0, 1'b0, 1'b0);
      exp_at("t2_c31", 31, 4'h1, 4'b1000, 1'b0, 1'b0, 1'b1);
      exp_at("t2_c32", 32, 4'h8, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t2_c36", 36, 4'h7, 4'b0010, 1'b0, 1'b1, 1'b0);
      exp_at("t2_c44", 44, 4'h5, 4'b1000, 1'b0, 1'b1, 1'b0);
      go(2);
      load_valid = 1'b1;
      load_data  = 16'h1234;
      go(3);
      load_data  = 16'h5678;
      go(17);
      load_valid = 1'b0;
      go(45);

      // Accept on a frame_tick cycle: shown a full frame later
      do_reset();
      exp_at("t3_c15", 15, 4'h0, 4'b1000, 1'b0, 1'b1, 1'b1);
      exp_at("t3_c16", 16, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b0);
      exp_at("t3_c31", 31, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b1);
      exp_at("t3_c32", 32, 4'h9, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t3_c36", 36, 4'h0, ben(4'b0010), BL, 1'b1, 1'b0);
      load(15, 16'h0009);
      go(37);

      // Reset mid-frame with the shadow full discards both buffers
      do_reset();
      exp_at("t4_c20", 20, 4'h3, 4'b0010, 1'b0, 1'b0, 1'b0);
      exp_at("t4_c22", 22, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t4_c25", 25, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t4_c26", 26, 4'h0, 4'b0010, 1'b0, 1'b1, 1'b0);
      exp_at("t4_c37", 37, 4'h0, 4'b1000, 1'b0, 1'b1, 1'b1);
      exp_at("t4_c38", 38, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
      load(2, 16'h1234);
      load(16, 16'h5678);
      go(21);
      rst = 1'b1;
      go(22);
      rst = 1'b0;
      go(39);

      // Leading zeros, all-zero value, embedded zero and digits above 9
      do_reset();
      exp_at("t5_c16", 16, 4'h2, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t5_c20", 20, 4'h4, 4'b0010, 1'b0, 1'b0, 1'b0);
      exp_at("t5_c24", 24, 4'h0, ben(4'b0100), BL, 1'b0, 1'b0);
      exp_at("t5_c28", 28, 4'h0, ben(4'b1000), BL, 1'b0, 1'b0);
      exp_at("t5_c32", 32, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t5_c36", 36, 4'h0, ben(4'b0010), BL, 1'b0, 1'b0);
      exp_at("t5_c40", 40, 4'h0, ben(4'b0100), BL, 1'b0, 1'b0);
      exp_at("t5_c48", 48, 4'hF, 4'b0001, 1'b0, 1'b1, 1'b0);
      exp_at("t5_c52", 52, 4'h0, 4'b0010, 1'b0, 1'b1, 1'b0);
      exp_at("t5_c56", 56, 4'hB, 4'b0100, 1'b0, 1'b1, 1'b0);
      exp_at("t5_c60", 60, 4'h0, ben(4'b1000), BL, 1'b1, 1'b0);
      load(2, 16'h0042);
      load(16, 16'h0000);
      load(32, 16'h0B0F);
      go(61);

      done = 1'b1;
   end

endmodule
